// File: rtl/cpu_host_sequencer.sv
// Host-side sequencer: loads, reads and clears shared memory, and launches the CPU
// for a fixed cycle budget before halting it and returning the bus to the host.
module cpu_host_sequencer #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int START_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_host_own,
    output logic              cpu_start,
    input  logic              cpu_done,
    output logic              cpu_rst
);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_WRITE, S_RD_ADDR, S_RD_WAIT, S_CLEAR,
        S_RUN_START, S_RUN_EXEC, S_HALT, S_HALT_WAIT, S_RSP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [ADDR_W-1:0] CNT_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_START  = ADDR_W'(START_CYC);
    localparam logic [ADDR_W-1:0] CNT_HALT_W = ADDR_W'(4);

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_cnt, w_cnt;
    logic [ADDR_W-1:0] r_addr, w_addr;

    logic              r_cmd_ready, w_cmd_ready;
    logic              r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data, w_rsp_data;
    logic              r_rsp_err, w_rsp_err;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic              r_mem_we, w_mem_we;
    logic              r_host_own, w_host_own;
    logic              r_cpu_start, w_cpu_start;
    logic              r_cpu_rst, w_cpu_rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_host_own  <= 1'b1;
            r_cpu_start <= 1'b0;
            r_cpu_rst   <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_addr      <= w_addr;
            r_cmd_ready <= w_cmd_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_we    <= w_mem_we;
            r_host_own  <= w_host_own;
            r_cpu_start <= w_cpu_start;
            r_cpu_rst   <= w_cpu_rst;
        end
    end

    // Output registers are loaded with the values belonging to the state being entered.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_addr      = r_addr;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_data  = r_rsp_data;
        w_rsp_err   = r_rsp_err;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        w_host_own  = 1'b1;
        w_cpu_start = 1'b0;
        w_cpu_rst   = 1'b0;

        case (r_state)
            S_INIT: begin
                w_state     = S_IDLE;
                w_cmd_ready = 1'b1;
                w_rsp_data  = '0;
                w_rsp_err   = 1'b0;
            end
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                w_rsp_data  = '0;
                w_rsp_err   = 1'b0;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready = 1'b0;
                    w_addr      = cmd_addr;
                    unique case (cmd_op)
                        OP_WRITE: begin
                            w_state     = S_WRITE;
                            w_mem_we    = 1'b1;
                            w_mem_addr  = cmd_addr;
                            w_mem_wdata = cmd_data;
                        end
                        OP_RUN: begin
                            if (!cpu_done || cmd_addr == '0) begin
                                w_state     = S_RSP;
                                w_rsp_valid = 1'b1;
                                w_rsp_err   = 1'b1;
                            end else begin
                                w_state     = S_RUN_START;
                                w_cnt       = CNT_START;
                                w_host_own  = 1'b0;
                                w_cpu_start = 1'b1;
                            end
                        end
                        OP_READ: begin
                            w_state    = S_RD_ADDR;
                            w_mem_addr = cmd_addr;
                        end
                        OP_CLEAR: begin
                            w_state    = S_CLEAR;
                            w_cnt      = '0;
                            w_mem_we   = 1'b1;
                            w_mem_addr = '0;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                w_state     = S_RSP;
                w_rsp_valid = 1'b1;
                w_rsp_data  = '0;
                w_rsp_err   = 1'b0;
            end
            S_RD_ADDR: begin
                w_state    = S_RD_WAIT;
                w_mem_addr = r_addr;
            end
            S_RD_WAIT: begin
                w_state     = S_RSP;
                w_rsp_valid = 1'b1;
                w_rsp_data  = mem_rdata;
                w_rsp_err   = 1'b0;
            end
            S_CLEAR: begin
                // Compare before increment so a clear up to the top address never wraps.
                if (r_cnt == r_addr) begin
                    w_state     = S_RSP;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = '0;
                    w_rsp_err   = 1'b0;
                end else begin
                    w_cnt      = r_cnt + CNT_ONE;
                    w_mem_we   = 1'b1;
                    w_mem_addr = r_cnt + CNT_ONE;
                end
            end
            S_RUN_START: begin
                w_host_own = 1'b0;
                if (r_cnt == CNT_ONE) begin
                    w_state = S_RUN_EXEC;
                    w_cnt   = r_addr;
                end else begin
                    w_cnt       = r_cnt - CNT_ONE;
                    w_cpu_start = 1'b1;
                end
            end
            S_RUN_EXEC: begin
                w_host_own = 1'b0;
                if (r_cnt == CNT_ONE) begin
                    w_state   = S_HALT;
                    w_cpu_rst = 1'b1;
                end else begin
                    w_cnt = r_cnt - CNT_ONE;
                end
            end
            S_HALT: begin
                w_state = S_HALT_WAIT;
                w_cnt   = CNT_HALT_W;
            end
            S_HALT_WAIT: begin
                if (cpu_done) begin
                    w_state     = S_RSP;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = '0;
                    w_rsp_err   = 1'b0;
                end else if (r_cnt == CNT_ONE) begin
                    w_state     = S_RSP;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = '0;
                    w_rsp_err   = 1'b1;
                end else begin
                    w_cnt = r_cnt - CNT_ONE;
                end
            end
            S_RSP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_rsp_data  = '0;
                    w_rsp_err   = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign cmd_ready    = r_cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_we       = r_mem_we;
    assign mem_host_own = r_host_own;
    assign cpu_start    = r_cpu_start;
    assign cpu_rst      = r_cpu_rst;

endmodule
